// File: rtl/friscv_pkg.sv
// Shared definitions for the FRISC-V juice machine: controller state encoding,
// juice identifiers and a small constant-evaluation helper.
package friscv_pkg;

    typedef enum logic [2:0] {
        DESLIGADO = 3'd0,
        OCIOSO    = 3'd1,
        BOMBA_1   = 3'd2,
        BOMBA_2   = 3'd3,
        PAUSA     = 3'd4
    } estado_t;

    localparam logic [1:0] SUCO_1 = 2'd1;
    localparam logic [1:0] SUCO_2 = 2'd2;

    function automatic int maior(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Single-bit rising-edge detector. History resets to 1 so that a level already
// high when reset is released never looks like a fresh press.
module detector_borda (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic borda_o
);

    logic hist_q;

    // History register: previous sample of the input
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= d_i;
        end
    end

    assign borda_o = d_i & ~hist_q;

endmodule

// File: rtl/controle_bombas.sv
// Dispense sequencer: turns juice-button presses into timed, mutually
// exclusive pump activations with a mandatory pause between dispenses.
module controle_bombas
    import friscv_pkg::*;
#(
    parameter int T_BOMBA = 100,
    parameter int T_PAUSA = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       liga,
    input  logic       pedido_1,
    input  logic       pedido_2,
    output logic       ativa_bomba_1,
    output logic       ativa_bomba_2,
    output logic       pronto,
    output logic [2:0] db_estado,
    output logic [1:0] db_pendentes
);

    localparam int CW = $clog2(maior(T_BOMBA, T_PAUSA) + 1);
    localparam logic [CW-1:0] FIM_BOMBA = CW'(T_BOMBA - 1);
    localparam logic [CW-1:0] FIM_PAUSA = CW'(T_PAUSA - 1);

    estado_t       estado_q;
    logic [CW-1:0] cnt_q;
    logic          pend_1_q;
    logic          pend_2_q;
    logic [1:0]    ultimo_q;
    logic          borda_1;
    logic          borda_2;
    logic          captura_1;
    logic          captura_2;

    detector_borda u_borda_1 (
        .clk_i   (clock),
        .rst_n_i (reset),
        .d_i     (pedido_1),
        .borda_o (borda_1)
    );

    detector_borda u_borda_2 (
        .clk_i   (clock),
        .rst_n_i (reset),
        .d_i     (pedido_2),
        .borda_o (borda_2)
    );

    // A press is only taken while enabled, out of DESLIGADO and not already pouring that juice
    assign captura_1 = borda_1 & liga & (estado_q != DESLIGADO) & (estado_q != BOMBA_1);
    assign captura_2 = borda_2 & liga & (estado_q != DESLIGADO) & (estado_q != BOMBA_2);

    // Sequencer FSM with phase counter, pending requests and last-served juice
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= DESLIGADO;
            cnt_q    <= '0;
            pend_1_q <= 1'b0;
            pend_2_q <= 1'b0;
            ultimo_q <= SUCO_2;
        end else if (!liga) begin
            estado_q <= DESLIGADO;
            cnt_q    <= '0;
            pend_1_q <= 1'b0;
            pend_2_q <= 1'b0;
        end else begin
            pend_1_q <= pend_1_q | captura_1;
            pend_2_q <= pend_2_q | captura_2;
            case (estado_q)
                DESLIGADO: begin
                    estado_q <= OCIOSO;
                    cnt_q    <= '0;
                end
                OCIOSO: begin
                    cnt_q <= '0;
                    // Entering a pump consumes its pending bit; ties go to the juice not served last
                    if (pend_1_q && (!pend_2_q || (ultimo_q == SUCO_2))) begin
                        estado_q <= BOMBA_1;
                        pend_1_q <= 1'b0;
                    end else if (pend_2_q) begin
                        estado_q <= BOMBA_2;
                        pend_2_q <= 1'b0;
                    end else begin
                        estado_q <= OCIOSO;
                    end
                end
                BOMBA_1, BOMBA_2: begin
                    if (cnt_q == FIM_BOMBA) begin
                        estado_q <= PAUSA;
                        cnt_q    <= '0;
                        ultimo_q <= (estado_q == BOMBA_1) ? SUCO_1 : SUCO_2;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PAUSA: begin
                    if (cnt_q == FIM_PAUSA) begin
                        estado_q <= OCIOSO;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    estado_q <= DESLIGADO;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign ativa_bomba_1 = (estado_q == BOMBA_1);
    assign ativa_bomba_2 = (estado_q == BOMBA_2);
    assign pronto        = (estado_q == OCIOSO);
    assign db_estado     = estado_q;
    assign db_pendentes  = {pend_2_q, pend_1_q};

endmodule

// File: tb/tb_controle_bombas.sv
// Randomized bench for controle_bombas against a deadline-based reference model
// of the dispense rules (phases end at absolute edge numbers, requests are a set).
module tb_controle_bombas;

    localparam int T_BOMBA = 4;
    localparam int T_PAUSA = 2;

    logic       clock;
    logic       reset;
    logic       liga;
    logic       pedido_1;
    logic       pedido_2;
    logic       ativa_bomba_1;
    logic       ativa_bomba_2;
    logic       pronto;
    logic [2:0] db_estado;
    logic [1:0] db_pendentes;

    int checks   = 0;
    int failures = 0;

    controle_bombas #(.T_BOMBA(T_BOMBA), .T_PAUSA(T_PAUSA)) dut (
        .clock         (clock),
        .reset         (reset),
        .liga          (liga),
        .pedido_1      (pedido_1),
        .pedido_2      (pedido_2),
        .ativa_bomba_1 (ativa_bomba_1),
        .ativa_bomba_2 (ativa_bomba_2),
        .pronto        (pronto),
        .db_estado     (db_estado),
        .db_pendentes  (db_pendentes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: machine mode, which juice is pouring, absolute phase deadline
    typedef enum int {M_POUR, M_REST, M_IDLE, M_OFF} modo_t;
    modo_t m_mode;
    int    m_juice, m_last, m_t, m_end;
    bit    m_p1, m_p2, m_prev1, m_prev2;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_OFF;
        m_juice = 0;
        m_last  = 2;
        m_p1    = 1'b0;
        m_p2    = 1'b0;
        m_prev1 = 1'b1;
        m_prev2 = 1'b1;
    endtask

    task automatic model_edge(input bit l, input bit b1, input bit b2);
        bit r1, r2, n1, n2;
        int j;
        r1 = b1 & ~m_prev1;
        r2 = b2 & ~m_prev2;
        m_prev1 = b1;
        m_prev2 = b2;
        m_t++;
        if (!l) begin
            m_mode = M_OFF;
            m_p1   = 1'b0;
            m_p2   = 1'b0;
        end else begin
            n1 = m_p1;
            n2 = m_p2;
            if (m_mode != M_OFF) begin
                if (r1 && !(m_mode == M_POUR && m_juice == 1)) n1 = 1'b1;
                if (r2 && !(m_mode == M_POUR && m_juice == 2)) n2 = 1'b1;
            end
            case (m_mode)
                M_OFF: m_mode = M_IDLE;
                M_IDLE: begin
                    if (m_p1 || m_p2) begin
                        if (m_p1 && m_p2) j = (m_last == 1) ? 2 : 1;
                        else              j = m_p1 ? 1 : 2;
                        m_mode  = M_POUR;
                        m_juice = j;
                        m_end   = m_t + T_BOMBA;
                        if (j == 1) n1 = 1'b0;
                        else        n2 = 1'b0;
                    end
                end
                M_POUR: begin
                    if (m_t == m_end) begin
                        m_mode = M_REST;
                        m_end  = m_t + T_PAUSA;
                        m_last = m_juice;
                    end
                end
                M_REST: if (m_t == m_end) m_mode = M_IDLE;
                default: m_mode = M_OFF;
            endcase
            m_p1 = n1;
            m_p2 = n2;
        end
    endtask

    function automatic int estado_esperado();
        case (m_mode)
            M_OFF:   return 0;
            M_IDLE:  return 1;
            M_POUR:  return (m_juice == 1) ? 2 : 3;
            M_REST:  return 4;
            default: return 7;
        endcase
    endfunction

    task automatic compare_all();
        check("bomba1",     int'(ativa_bomba_1), int'(m_mode == M_POUR && m_juice == 1));
        check("bomba2",     int'(ativa_bomba_2), int'(m_mode == M_POUR && m_juice == 2));
        check("pronto",     int'(pronto),        int'(m_mode == M_IDLE));
        check("estado",     int'(db_estado),     estado_esperado());
        check("pendentes",  int'(db_pendentes),  int'({m_p2, m_p1}));
        check("exclusao",   int'(ativa_bomba_1 & ativa_bomba_2), 0);
    endtask

    // Drive inputs at the negedge, advance the model with the DUT edge, compare at the next negedge
    task automatic step(input bit l, input bit b1, input bit b2);
        liga     = l;
        pedido_1 = b1;
        pedido_2 = b2;
        @(posedge clock);
        if (!reset) model_reset();
        else        model_edge(l, b1, b2);
        @(negedge clock);
        compare_all();
    endtask

    bit l_r, b1_r, b2_r;
    int off_cnt;

    initial begin
        reset    = 1'b0;
        liga     = 1'b0;
        pedido_1 = 1'b0;
        pedido_2 = 1'b0;
        m_t      = 0;
        m_end    = 0;
        model_reset();
        @(negedge clock);
        compare_all();
        step(1'b1, 1'b0, 1'b0);
        reset = 1'b1;

        // Single dispense, queued request, simultaneous presses
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b1);
            for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
        end

        // Repeated presses during one dispense, then abort mid-pump
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional disable pulses
        l_r = 1'b1; b1_r = 1'b0; b2_r = 1'b0; off_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (off_cnt > 0) off_cnt--;
            else if ($urandom_range(79, 0) == 0) off_cnt = $urandom_range(3, 1);
            l_r = (off_cnt == 0);
            if ($urandom_range(3, 0) == 0) b1_r = ~b1_r;
            if ($urandom_range(3, 0) == 0) b2_r = ~b2_r;
            step(l_r, b1_r, b2_r);
        end

        // Async reset in the middle of a juice-2 dispense with button 1 held
        for (int i = 0; i < 40 && !(m_mode == M_IDLE && !m_p1 && !m_p2); i++)
            step(1'b1, 1'b0, 1'b0);
        check("ocioso_antes_reset", int'(m_mode == M_IDLE), 1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("bomba2_antes_reset", int'(ativa_bomba_2), 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
        check("sem_pedido_pos_reset", int'(db_pendentes), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controle_bombas.md
# controle_bombas

Dispense sequencer for the FRISC-V juice machine: turns the two juice-button requests into timed, mutually exclusive activations of pump 1 and pump 2. It sits between the button inputs and the `ativa_bomba_1`/`ativa_bomba_2` outputs of the top level. It queues a request that arrives while the other juice is pouring, and alternates priority when both juices are pending.

## Interface
- `T_BOMBA`, default 100: pump-on time per dispense, in clock cycles (≥1).
- `T_PAUSA`, default 10: mandatory idle gap after each dispense, in clock cycles (≥1).
- `clock` in 1: single system clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-low (0 = reset asserted).
- `liga` in 1: machine enable level (from `liga_frisc`).
- `pedido_1` in 1: juice-1 button, already synchronized to `clock`.
- `pedido_2` in 1: juice-2 button, already synchronized to `clock`.
- `ativa_bomba_1` out 1: drive pump 1.
- `ativa_bomba_2` out 1: drive pump 2.
- `pronto` out 1: high in OCIOSO.
- `db_estado` out 3: state encoding, for debug.
- `db_pendentes` out 2: {pend_2, pend_1}, for debug.

## Operation
- States: DESLIGADO, OCIOSO, BOMBA_1, BOMBA_2, PAUSA.
- Reset values: state DESLIGADO; pend_1, pend_2, counter = 0; `ultimo` (last served) = 2; edge-detector history = 1, so a button held through reset is not a request.
- All outputs are Moore outputs decoded from the state register:
  - `ativa_bomba_1` = (BOMBA_1).
  - `ativa_bomba_2` = (BOMBA_2).
  - After reset every output is 0, and `db_estado` shows DESLIGADO.
- Request capture:
  - A 0→1 transition of `pedido_x` is sampled at edge k, with `liga`=1 and state ≠ DESLIGADO.
  - It sets pend_x at edge k.
  - It is ignored if pend_x is already 1 or the block is in BOMBA_x. There is no counting of repeated presses.
- pend_x clears on the edge that enters BOMBA_x.
- DESLIGADO → OCIOSO when `liga`=1. Button edges seen in DESLIGADO are discarded.
- OCIOSO:
  - Only pend_1 set → BOMBA_1. Only pend_2 set → BOMBA_2.
  - Both set → the juice ≠ `ultimo`.
  - Neither set → stay in OCIOSO.
- BOMBA_x:
  - The counter clears on entry and increments each cycle.
  - When the counter reaches T_BOMBA−1 → PAUSA, and `ultimo` ← x.
- PAUSA: counter reuse. At T_PAUSA−1 → OCIOSO. New edges are still captured into pend.
- Counter width = clog2(max(T_BOMBA,T_PAUSA)+1). The counter never wraps; it clears on every state change.
- `liga`=0 in any state:
  - Next edge → DESLIGADO. pend_1, pend_2 and the counter clear; `ultimo` is kept.
  - An in-progress dispense is aborted, and its pump drops after that edge.
- Simultaneous rising edges on both buttons in the same cycle: both pend bits set. They are served in tie-break order, one after the other.
- Asynchronous reset mid-dispense: pumps go low immediately, without waiting for the clock.

## Timing
- Request latency:
  - Edge sampled at clock edge k (state OCIOSO) → pend set after edge k.
  - BOMBA_x entered at edge k+1.
  - Pump high for exactly T_BOMBA cycles.
- Dispense to dispense:
  - T_BOMBA pump cycles, then T_PAUSA gap cycles, then 1 OCIOSO cycle, then the next pump.
  - The minimum gap between pump-off and the next pump-on is therefore T_PAUSA+1 cycles.
- The two pumps are never high in the same cycle.
- `liga` 0→1: OCIOSO one edge later. A button edge sampled in that same cycle is discarded.

## Structure
- Shared package `friscv_pkg` holds:
  - The state type and its 3-bit encoding: DESLIGADO=0, OCIOSO=1, BOMBA_1=2, BOMBA_2=3, PAUSA=4.
  - Juice identifier constants SUCO_1=1 and SUCO_2=2, used for `ultimo`.
- Sub-module `detector_borda`: 1-bit rising-edge detector with asynchronous active-low reset and history reset value 1. It is instantiated once per button.
- Everything else (FSM, counter, pend/`ultimo` registers) lives in `controle_bombas`.

## Test plan
All scenarios use T_BOMBA=4, T_PAUSA=2.
- Single dispense:
  - Stimulus: `liga`=1, then a `pedido_1` pulse sampled at edge 10.
  - Required: `ativa_bomba_1` high in cycles 11–14. PAUSA in 15–16. `pronto` high from cycle 17. `ativa_bomba_2` never high.
- Queued request:
  - Stimulus: `pedido_1` at edge 10, then `pedido_2` at edge 12.
  - Required: bomba_1 high in 11–14, bomba_2 high in 18–21. `db_pendentes`=2'b10 during cycles 12–17.
- Tie alternation:
  - Stimulus: both buttons rise at edge 10, twice in a row (the second time after the first pair completes).
  - Required: first pair served 1 then 2; second pair served 1 then 2 again, since `ultimo`=2 each time. Pumps are never high in the same cycle.
- Abort:
  - Stimulus: `liga`=0 during cycle 12 of a BOMBA_1 dispense.
  - Required: pump low from cycle 13. State DESLIGADO, `db_pendentes`=0. Raising `liga` again gives no automatic dispense.
- Reset:
  - Stimulus: `reset`=0 mid-BOMBA_2, with `pedido_1` held high through and after the reset release.
  - Required: pumps drop immediately. All outputs are 0 and `db_estado`=0. The held button produces no request after release.
- Repeated press:
  - Stimulus: three `pedido_1` pulses during one BOMBA_1 dispense.
  - Required: no extra dispense.
